// File: rtl/key_sync_debounce_pkg.sv
// Shared keypad constants for the row input conditioner and its single-channel cell.
// Rows idle high through pull-ups, so a pressed key reads 0.
package key_sync_debounce_pkg;

  localparam int KP_ROWS             = 4;
  localparam int KP_COLS             = 4;
  localparam int KP_DEBOUNCE_DEFAULT = 3;
  localparam int KP_SYNC_DEFAULT     = 2;
  localparam logic [KP_ROWS-1:0] KP_ROW_IDLE = 4'b1111;

  // Counter must be able to hold 0..DEBOUNCE_CNT without wrapping.
  function automatic int cntWidth(input int debounceCnt);
    return (debounceCnt < 1) ? 1 : $clog2(debounceCnt + 1);
  endfunction

endpackage

// File: rtl/key_sync_debounce_cell.sv
// One keypad row: synchronizer chain, debounce counter, registered q/qbar and rise/fall pulses.
// pulseNext_o exposes next-cycle pulse state so the top can register 'changed' alongside the pulses.
module key_debounce_cell
  import key_sync_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES  = KP_SYNC_DEFAULT,
  parameter int   DEBOUNCE_CNT = KP_DEBOUNCE_DEFAULT,
  parameter logic RESET_VAL    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic d_i,
  output logic q_o,
  output logic qbar_o,
  output logic rise_o,
  output logic fall_o,
  output logic pulseNext_o
);

  localparam int CNT_W = cntWidth(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic [SYNC_STAGES-1:0] syncQ, syncD;
  logic [CNT_W-1:0]       cntQ, cntD;
  logic levelQ, levelD, levelBarQ, levelBarD;
  logic riseQ, riseD, fallQ, fallD;
  logic syncOut;

  assign syncOut = syncQ[SYNC_STAGES-1];

  // The chain shifts every clock; only the counter and level wait for the sample tick.
  always_comb begin
    syncD     = {syncQ[SYNC_STAGES-2:0], d_i};
    cntD      = cntQ;
    levelD    = levelQ;
    levelBarD = levelBarQ;
    riseD     = 1'b0;
    fallD     = 1'b0;
    if (enable) begin
      if (syncOut == levelQ) begin
        cntD = '0;
      end else if (cntQ == CNT_LAST) begin
        levelD    = syncOut;
        levelBarD = ~syncOut;
        cntD      = '0;
        riseD     = syncOut;
        fallD     = ~syncOut;
      end else begin
        cntD = cntQ + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      syncQ     <= {SYNC_STAGES{RESET_VAL}};
      cntQ      <= '0;
      levelQ    <= RESET_VAL;
      levelBarQ <= ~RESET_VAL;
      riseQ     <= 1'b0;
      fallQ     <= 1'b0;
    end else begin
      syncQ     <= syncD;
      cntQ      <= cntD;
      levelQ    <= levelD;
      levelBarQ <= levelBarD;
      riseQ     <= riseD;
      fallQ     <= fallD;
    end
  end

  assign q_o         = levelQ;
  assign qbar_o      = levelBarQ;
  assign rise_o      = riseQ;
  assign fall_o      = fallQ;
  assign pulseNext_o = riseD | fallD;

endmodule

// File: rtl/key_sync_debounce.sv
// Multi-channel keypad row conditioner: WIDTH independent debounce cells
// plus a single registered 'changed' flag covering all channel pulses.
module key_sync_debounce
  import key_sync_debounce_pkg::*;
#(
  parameter int               WIDTH        = KP_ROWS,
  parameter int               SYNC_STAGES  = KP_SYNC_DEFAULT,
  parameter int               DEBOUNCE_CNT = KP_DEBOUNCE_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VAL    = WIDTH'(KP_ROW_IDLE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  logic [WIDTH-1:0] pulseNext;
  logic             changedQ;

  for (genvar i = 0; i < WIDTH; i++) begin : gCell
    key_debounce_cell #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CNT(DEBOUNCE_CNT),
      .RESET_VAL   (RESET_VAL[i])
    ) uCell (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .d_i        (d[i]),
      .q_o        (q[i]),
      .qbar_o     (qbar[i]),
      .rise_o     (rise[i]),
      .fall_o     (fall[i]),
      .pulseNext_o(pulseNext[i])
    );
  end

  // Built from the cells' next-state pulses so it lands in the same cycle as rise/fall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      changedQ <= 1'b0;
    end else begin
      changedQ <= |pulseNext;
    end
  end

  assign changed = changedQ;

endmodule

// File: doc/key_sync_debounce.md
Name: key_sync_debounce

Overview:
Multi-channel input conditioner for the 4x4 keypad reader. It brings raw, asynchronous keypad row lines into the fast clock domain through a per-channel synchronizer chain. Each channel is then debounced on a slow sample tick (enable) and produces a registered level (q/qbar) plus one-cycle rise and fall pulses. It sits between the keypad row pins and the scan/decode FSM, and replaces the per-row single enable flip-flops.

Parameters:
WIDTH, 4, number of independent input channels (keypad rows).
SYNC_STAGES, 2, synchronizer flops per channel. Legal range is 2 or more, always clocked by clk and never gated by enable.
DEBOUNCE_CNT, 3, consecutive enable ticks a new synchronized value must hold before q changes. Legal range is 1 or more; 1 gives plain enabled-register behaviour.
RESET_VAL, {WIDTH{1'b1}}, reset value of sync chain and q. Rows are pulled up, so a pressed key reads 0.

Ports:
clk  input  1  system clock; the only clock in the block.
rst  input  1  reset, synchronous, active-low; sampled on posedge clk.
enable  input  1  one-clk-wide sample tick from the slow-clock divider.
d  input  WIDTH  raw asynchronous row inputs.
q  output  WIDTH  debounced level, registered.
qbar  output  WIDTH  bitwise complement of q, registered. Always equals ~q, including during reset.
rise  output  WIDTH  one-clk pulse when q[i] goes 0->1.
fall  output  WIDTH  one-clk pulse when q[i] goes 1->0 (key press).
changed  output  1  OR of rise|fall, registered in the same cycle as the pulses.

Behaviour:
- Reset (rst==0 at posedge clk): all sync stages = RESET_VAL, q = RESET_VAL, qbar = ~RESET_VAL, all counters = 0, rise = fall = changed = 0. Reset overrides enable. Reset asserted mid-count discards the count.
- Sync chain: shifts on every clk edge regardless of enable. s[i] denotes the last stage.
- Per channel i, per clk edge, when not in reset:
  - enable==0: cnt[i] and q[i] hold; rise[i] = fall[i] = 0.
  - enable==1 and s[i]==q[i]: cnt[i] <= 0; no pulse. A glitch shorter than DEBOUNCE_CNT ticks is rejected.
  - enable==1 and s[i]!=q[i] and cnt[i] < DEBOUNCE_CNT-1: cnt[i] <= cnt[i]+1.
  - enable==1 and s[i]!=q[i] and cnt[i]==DEBOUNCE_CNT-1: q[i] <= s[i]; qbar[i] <= ~s[i]; cnt[i] <= 0; rise[i] or fall[i] <= 1 for exactly this cycle.
- Pulses are registered and deassert the next clk. They never last more than one clk, even if enable is held high.
- Counter width is $clog2(DEBOUNCE_CNT+1); the counter never wraps.
- Latency:
  - d edge to s: SYNC_STAGES clks.
  - s stable to q update: DEBOUNCE_CNT enable ticks, counting the first tick that samples the new s.
  - With enable held high: SYNC_STAGES + DEBOUNCE_CNT clks from d edge to q.
- Channels are fully independent. Simultaneous transitions on several channels may pulse in the same cycle, and changed is 1 once.
- If enable is constantly 0, q never changes.

Decomposition:
- Shared keypad package/include holds the constants KP_ROWS=4, KP_COLS=4, KP_DEBOUNCE_DEFAULT=3 and KP_ROW_IDLE=4'b1111. The top-level passes these into WIDTH/DEBOUNCE_CNT/RESET_VAL.
- One sub-module, key_debounce_cell: a single channel with sync chain, counter, q/qbar and rise/fall, with the same parameters minus WIDTH. The top-level is a generate loop of WIDTH cells plus the changed OR-register.

Test Plan:
1. Reset: hold rst=0 for 3 clks with d=4'b0000 and enable=1 -> q=4'b1111, qbar=4'b0000, rise=fall=0, changed=0 throughout and on the first clk after release.
2. Clean press: rst=1, enable=1 constant, d[2] 1->0 at t0 -> q=4'b1011 exactly 5 clks later (2 sync + 3 ticks). fall=4'b0100 for 1 clk, changed=1 for 1 clk, qbar=4'b0100.
3. Glitch rejection: enable tick every 8 clks, d[0] low for 2 ticks then high -> q stays 4'b1111 and no pulses. Then d[0] low for 3 ticks -> q[0]=0 on the 3rd tick and fall[0] pulses once.
4. Enable gating: d[1]=0 stable, enable=0 for 50 clks -> q unchanged and counter held. Then 3 enable ticks -> q[1]=0 on the 3rd.
5. Simultaneous/release: d=4'b0110 settled, then d=4'b1111 with enable=1 -> q returns to 4'b1111. rise=4'b1001 in one cycle, changed=1 for exactly 1 clk.
6. Reset mid-count: d[3]=0, 2 ticks counted, rst=0 for 1 clk, then rst=1 -> q[3] still 1. Three further ticks are needed before fall[3] pulses.
